// File: rtl/mmio_timer_bank.sv
// Multi-channel MMIO compare timer bank with a shared prescaler.
// Optional capture inputs are enabled with `define TIMER_CAPTURE_EN.
module mmio_timer_bank #(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 16,
  parameter int ADDR_W  = 6
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
`ifdef TIMER_CAPTURE_EN
  input  logic [NUM_CH-1:0] cap_in,
`endif
  output logic [31:0]       dout,
  output logic              irq,
  output logic [NUM_CH-1:0] ch_irq
);

  localparam logic [ADDR_W-1:0] PRESC_ADDR = ADDR_W'(NUM_CH * 8);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [NUM_CH-1:0]  en_q, en_d, auto_q, auto_d;
  logic [NUM_CH-1:0]  ie_q, ie_d, match_q, match_d;
  logic [NUM_CH-1:0]  ch_irq_q, ch_irq_d;
  logic [WIDTH-1:0]   cmp_q [NUM_CH];
  logic [WIDTH-1:0]   cmp_d [NUM_CH];
  logic [WIDTH-1:0]   cnt_q [NUM_CH];
  logic [WIDTH-1:0]   cnt_d [NUM_CH];
  logic [31:0]        dout_q, dout_d, rdata;
  logic [NUM_CH-1:0]  sel, hit;
  logic               tick, wr_presc;
  logic               unused_din;

  assign unused_din = ^din;

`ifdef TIMER_CAPTURE_EN
  logic [NUM_CH-1:0] cie_q, cie_d, capf_q, capf_d;
  logic [NUM_CH-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [NUM_CH-1:0] rise;
  logic [WIDTH-1:0]  cap_q [NUM_CH];
  logic [WIDTH-1:0]  cap_d [NUM_CH];

  assign s1_d = cap_in;
  assign s2_d = s1_q;
  assign s3_d = s2_q;
  assign rise = s2_q & ~s3_q;
`endif

  always_comb begin
    tick     = (presc_cnt_q == presc_q);
    wr_presc = wr_en && (addr == PRESC_ADDR);
    sel      = '0;
    hit      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel[c] = (addr[ADDR_W-1:3] == (ADDR_W-3)'(c));
      hit[c] = tick && en_q[c] && (cnt_q[c] == cmp_q[c]);
    end
  end

  always_comb begin
    presc_d     = presc_q;
    presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
    en_d        = en_q;
    auto_d      = auto_q;
    ie_d        = ie_q;
    match_d     = match_q | hit;
    cmp_d       = cmp_q;
    cnt_d       = cnt_q;
`ifdef TIMER_CAPTURE_EN
    cie_d       = cie_q;
    capf_d      = capf_q | rise;
    cap_d       = cap_q;
`endif
    if (wr_presc) begin
      presc_d     = din[PRESC_W-1:0];
      presc_cnt_d = '0;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (tick && en_q[c]) begin
        if (hit[c]) begin
          if (auto_q[c]) cnt_d[c] = '0;
          else           en_d[c]  = 1'b0;
        end else begin
          cnt_d[c] = cnt_q[c] + 1'b1;
        end
      end
`ifdef TIMER_CAPTURE_EN
      if (rise[c]) cap_d[c] = cnt_q[c];
`endif
      // Bus writes override tick effects; a fresh match beats W1C.
      if (wr_en && sel[c]) begin
        case (addr[2:0])
          3'd0: begin
            en_d[c]   = din[0];
            auto_d[c] = din[1];
            ie_d[c]   = din[2];
`ifdef TIMER_CAPTURE_EN
            cie_d[c]  = din[3];
`endif
          end
          3'd1: cmp_d[c] = din[WIDTH-1:0];
          3'd2: cnt_d[c] = din[WIDTH-1:0];
          3'd3: begin
            if (din[0] && !hit[c]) match_d[c] = 1'b0;
`ifdef TIMER_CAPTURE_EN
            if (din[1] && !rise[c]) capf_d[c] = 1'b0;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel[c]) begin
        case (addr[2:0])
`ifdef TIMER_CAPTURE_EN
          3'd0: rdata = {28'd0, cie_q[c], ie_q[c],
                         auto_q[c], en_q[c]};
          3'd3: rdata = {30'd0, capf_q[c], match_q[c]};
          3'd5: rdata = 32'(cap_q[c]);
`else
          3'd0: rdata = {29'd0, ie_q[c], auto_q[c], en_q[c]};
          3'd3: rdata = {31'd0, match_q[c]};
`endif
          3'd1: rdata = 32'(cmp_q[c]);
          3'd2: rdata = 32'(cnt_q[c]);
          default: rdata = '0;
        endcase
      end
    end
    if (addr == PRESC_ADDR) rdata = 32'(presc_q);
    dout_d   = rd_en ? rdata : dout_q;
    ch_irq_d = match_q & ie_q;
`ifdef TIMER_CAPTURE_EN
    ch_irq_d = ch_irq_d | (capf_q & cie_q);
`endif
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      presc_q     <= '0;
      presc_cnt_q <= '0;
      en_q        <= '0;
      auto_q      <= '0;
      ie_q        <= '0;
      match_q     <= '0;
      ch_irq_q    <= '0;
      dout_q      <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        cmp_q[c] <= '0;
        cnt_q[c] <= '0;
      end
    end else begin
      presc_q     <= presc_d;
      presc_cnt_q <= presc_cnt_d;
      en_q        <= en_d;
      auto_q      <= auto_d;
      ie_q        <= ie_d;
      match_q     <= match_d;
      ch_irq_q    <= ch_irq_d;
      dout_q      <= dout_d;
      for (int c = 0; c < NUM_CH; c++) begin
        cmp_q[c] <= cmp_d[c];
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

`ifdef TIMER_CAPTURE_EN
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      cie_q  <= '0;
      capf_q <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      for (int c = 0; c < NUM_CH; c++) cap_q[c] <= '0;
    end else begin
      cie_q  <= cie_d;
      capf_q <= capf_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      for (int c = 0; c < NUM_CH; c++) cap_q[c] <= cap_d[c];
    end
  end
`endif

  assign dout   = dout_q;
  assign ch_irq = ch_irq_q;
  assign irq    = |ch_irq_q;

endmodule

// File: tb/tb_mmio_timer_bank.sv
// Directed bench for mmio_timer_bank: register table plus timing sequences.
// A second WIDTH=8, NUM_CH=2 instance shares the bus for width checks.
module tb_mmio_timer_bank;

  logic        clk = 1'b0;
  logic        Rst;
  logic        wr_en, rd_en;
  logic [5:0]  addr;
  logic [31:0] din, dout, dout8;
  logic        irq, irq8;
  logic [3:0]  ch_irq;
  logic [1:0]  ch_irq8;
`ifdef TIMER_CAPTURE_EN
  logic [3:0]  cap_in;
  logic [1:0]  cap_in8;
`endif

  int checks = 0;
  int errors = 0;

  mmio_timer_bank u_dut (
    .clk(clk), .Rst(Rst), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .din(din),
`ifdef TIMER_CAPTURE_EN
    .cap_in(cap_in),
`endif
    .dout(dout), .irq(irq), .ch_irq(ch_irq)
  );

  mmio_timer_bank #(.NUM_CH(2), .WIDTH(8)) u_dut8 (
    .clk(clk), .Rst(Rst), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .din(din),
`ifdef TIMER_CAPTURE_EN
    .cap_in(cap_in8),
`endif
    .dout(dout8), .irq(irq8), .ch_irq(ch_irq8)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [5:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    addr  = a;
    din   = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] q);
    addr  = a;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    q     = dout;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] q;
    logic [31:0] wexp [5];

    tbl[0]  = '{1'b1, 6'd1,  32'h0000_1234, 32'h0};
    tbl[1]  = '{1'b0, 6'd1,  32'h0,         32'h0000_1234};
    tbl[2]  = '{1'b1, 6'd0,  32'hFFFF_FFF6, 32'h0};
    tbl[3]  = '{1'b0, 6'd0,  32'h0,         32'h6};
    tbl[4]  = '{1'b1, 6'd2,  32'h0000_DEAD, 32'h0};
    tbl[5]  = '{1'b0, 6'd2,  32'h0,         32'h0000_DEAD};
    tbl[6]  = '{1'b0, 6'd3,  32'h0,         32'h0};
    tbl[7]  = '{1'b0, 6'd4,  32'h0,         32'h0};
    tbl[8]  = '{1'b0, 6'd6,  32'h0,         32'h0};
    tbl[9]  = '{1'b1, 6'd32, 32'h000A_BCD5, 32'h0};
    tbl[10] = '{1'b0, 6'd32, 32'h0,         32'h0000_BCD5};
    tbl[11] = '{1'b1, 6'd63, 32'h0000_FFFF, 32'h0};
    tbl[12] = '{1'b0, 6'd63, 32'h0,         32'h0};
    tbl[13] = '{1'b0, 6'd33, 32'h0,         32'h0};
    tbl[14] = '{1'b1, 6'd0,  32'h0,         32'h0};
    tbl[15] = '{1'b1, 6'd32, 32'h0,         32'h0};

    Rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; din = '0;
`ifdef TIMER_CAPTURE_EN
    cap_in = '0; cap_in8 = '0;
`endif
    @(negedge clk);
    @(negedge clk);
    chk("reset dout", dout, 32'h0);
    chk("reset irq", {31'd0, irq}, 32'h0);
    chk("reset ch_irq", {28'd0, ch_irq}, 32'h0);
    chk("reset dout8", dout8, 32'h0);
    Rst = 1'b0;
    @(negedge clk);
    rd(6'd2, q);
    chk("reset cnt0", q, 32'h0);

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) begin
        wr(tbl[i].a, tbl[i].d);
      end else begin
        rd(tbl[i].a, q);
        chk($sformatf("table[%0d] addr %0d", i, tbl[i].a), q, tbl[i].exp);
      end
    end

    // auto-reload ch0, PRESC=0
    wr(6'd2, 32'd0);
    wr(6'd1, 32'd9);
    wr(6'd0, 32'h7);
    addr  = 6'd2;
    rd_en = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      chk($sformatf("auto cnt k=%0d", k), dout,
          (k <= 10) ? 32'(k - 1) : 32'd0);
      chk($sformatf("auto irq k=%0d", k), {31'd0, irq},
          (k == 11) ? 32'd1 : 32'd0);
    end
    rd_en = 1'b0;
    wr(6'd0, 32'h6);
    chk("auto irq held", {31'd0, irq}, 32'd1);
    rd(6'd3, q);
    chk("auto stat0", q, 32'd1);
    wr(6'd3, 32'd1);
    @(negedge clk);
    chk("auto irq cleared", {31'd0, irq}, 32'd0);
    chk("auto ch_irq cleared", {28'd0, ch_irq}, 32'd0);
    rd(6'd3, q);
    chk("auto stat0 cleared", q, 32'd0);

    // one-shot ch1 with PRESC=3
    wr(6'd9, 32'd2);
    wr(6'd10, 32'd0);
    wr(6'd32, 32'd3);
    wr(6'd8, 32'h1);
    repeat (10) @(negedge clk);
    rd(6'd11, q);
    chk("oneshot stat1 early", q, 32'd0);
    rd(6'd11, q);
    chk("oneshot stat1 match", q, 32'd1);
    rd(6'd10, q);
    chk("oneshot cnt1 held", q, 32'd2);
    rd(6'd8, q);
    chk("oneshot ctrl1 en cleared", q, 32'd0);
    chk("oneshot no irq", {31'd0, irq}, 32'd0);
    wr(6'd32, 32'd0);

    // wrap on ch2
    wr(6'd18, 32'hFFFF_FFFE);
    wr(6'd17, 32'd1);
    wr(6'd16, 32'h1);
    wexp[0] = 32'hFFFF_FFFE;
    wexp[1] = 32'hFFFF_FFFF;
    wexp[2] = 32'h0;
    wexp[3] = 32'h1;
    wexp[4] = 32'h1;
    addr  = 6'd18;
    rd_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("wrap cnt2 step %0d", k), dout, wexp[k]);
    end
    rd_en = 1'b0;
    rd(6'd19, q);
    chk("wrap stat2", q, 32'd1);
    rd(6'd16, q);
    chk("wrap ctrl2 en cleared", q, 32'd0);

    // W1C on the match edge of ch3
    wr(6'd25, 32'd3);
    wr(6'd26, 32'd0);
    wr(6'd24, 32'h1);
    repeat (3) @(negedge clk);
    wr(6'd27, 32'd1);
    rd(6'd27, q);
    chk("w1c vs match stat3", q, 32'd1);
    rd(6'd26, q);
    chk("w1c vs match cnt3", q, 32'd3);

    // CNT write on a tick
    wr(6'd27, 32'd1);
    wr(6'd25, 32'd100);
    wr(6'd24, 32'h1);
    repeat (2) @(negedge clk);
    wr(6'd26, 32'd5);
    rd(6'd26, q);
    chk("cnt write beats tick", q, 32'd5);
    wr(6'd24, 32'h0);

    // read returns pre-write value
    addr  = 6'd25;
    din   = 32'd77;
    wr_en = 1'b1;
    rd_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("read pre-write value", dout, 32'd100);
    rd(6'd25, q);
    chk("read post-write value", q, 32'd77);

    // narrow instance
    wr(6'd1, 32'h1FF);
    rd(6'd1, q);
    chk("cmp0 wide", q, 32'h1FF);
    chk("cmp0 narrow", dout8, 32'hFF);
    rd(6'd17, q);
    chk("narrow unmapped ch2", dout8, 32'h0);

`ifdef TIMER_CAPTURE_EN
    wr(6'd2, 32'd0);
    wr(6'd1, 32'd100);
    wr(6'd0, 32'h1);
    repeat (5) @(negedge clk);
    cap_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    rd(6'd5, q);
    chk("capture cap0", q, 32'd7);
    rd(6'd3, q);
    chk("capture capf0", q, 32'h2);
    wr(6'd0, 32'h0);
    cap_in[0] = 1'b0;
`endif

    // reset mid-run
    wr(6'd1, 32'd2);
    wr(6'd2, 32'd0);
    wr(6'd0, 32'h7);
    repeat (6) @(negedge clk);
    rd(6'd0, q);
    chk("pre-reset ctrl0", q, 32'h7);
    chk("pre-reset irq", {31'd0, irq}, 32'd1);
    #2 Rst = 1'b1;
    #1;
    chk("async reset dout", dout, 32'h0);
    chk("async reset irq", {31'd0, irq}, 32'd0);
    chk("async reset ch_irq", {28'd0, ch_irq}, 32'd0);
    @(negedge clk);
    Rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      rd(6'(c * 8 + 2), q);
      chk($sformatf("post-reset cnt%0d", c), q, 32'd0);
    end
    rd(6'd0, q);
    chk("post-reset ctrl0", q, 32'd0);
    rd(6'd1, q);
    chk("post-reset cmp0", q, 32'd0);
    rd(6'd3, q);
    chk("post-reset stat0", q, 32'd0);
    @(negedge clk);
    chk("post-reset irq", {31'd0, irq}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
